// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter and the blocks around it.
//   arb_state_e   : arbiter FSM encoding (idle / locked to one owner)
//   DefAddrWidth  : default BRAM address width, shared with datapath and bram
//   DefDataWidth  : default BRAM data width, shared with datapath and bram
//   idx_width()   : width of a requester index for a given requester count
package bram_port_arbiter_pkg;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDataWidth = 16;

  // Never returns 0 so a single-requester build still gets a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Searches req upward starting just after the last granted index, wrapping
// modulo NUM_REQ, so the last winner has the lowest priority.
//   req   : request vector
//   last  : index granted most recently
//   gnt   : one-hot grant (zero when no request)
//   idx   : index of the granted requester (0 when no request)
//   valid : any request was picked
module bram_port_arbiter_rr_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(last) + off) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous BRAM port between NUM_REQ requesters.
// Round-robin arbitration with an optional bounded burst lock; grants are
// combinational, read data returns one cycle after a granted read.
//   clk, rst          : clock, asynchronous active-low reset
//   req, lock, we     : per-requester request / keep-port / write strobe
//   addr, wdata       : flattened per-requester address and write data
//   gnt               : one-hot (or zero) grant; the access happens this cycle
//   rvalid, rdata     : per-requester read valid, shared read data
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata : BRAM port pins
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        last_gnt_q, last_gnt_d;
  logic [CntW-1:0]        burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]     rvalid_q;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;
  logic [IdxW-1:0]        gnt_idx;
  logic                   gnt_any;

  bram_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .last  (last_gnt_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    last_gnt_d  = last_gnt_q;
    gnt         = '0;
    gnt_idx     = owner_q;
    gnt_any     = 1'b0;
    // Grants are suppressed while reset is held so the port stays quiet.
    if (rst) begin
      case (state_q)
        ArbIdle: begin
          if (pick_valid) begin
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
            gnt_any = 1'b1;
            // With MAX_BURST of 1 a lock could never grant a second time.
            if (lock[pick_idx] && (MAX_BURST > 1)) begin
              state_d     = ArbLocked;
              owner_d     = pick_idx;
              burst_cnt_d = CntW'(1);
            end
          end
        end
        ArbLocked: begin
          if (req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            gnt_any      = 1'b1;
            burst_cnt_d  = burst_cnt_q + CntW'(1);
            if (!lock[owner_q] || (burst_cnt_d == CntW'(MAX_BURST))) begin
              state_d = ArbIdle;
            end
          end else begin
            // Owner dropped its request: release the port without a grant.
            state_d = ArbIdle;
          end
        end
        default: state_d = ArbIdle;
      endcase
    end
    // last_gnt = old owner after a burst, so round-robin skips it next.
    if (gnt_any) begin
      last_gnt_d = gnt_idx;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      mem_addr  = addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata = wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mem_we = |(gnt & we);
  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ArbIdle;
      owner_q     <= '0;
      last_gnt_q  <= IdxW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= gnt & ~we;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: two requesters, MAX_BURST = 4,
// with a small read-first synchronous BRAM model on the memory side.
module tb_bram_port_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req, lock, we;
  logic [31:0]   addr, wdata;
  logic [NR-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_addr_w, mem_wdata, mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  bram_port_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_addr_w = mem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr_w[7:0]];
    if (mem_we) mem[mem_addr_w[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge, where new inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w);
    req  = r;
    lock = l;
    we   = w;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 16'h2000;
    mem[8'h41] = 16'h3000;
    mem_rdata  = '0;
    rst   = 1'b0;
    drive(2'b11, 2'b00, 2'b00);
    addr  = {16'h0041, 16'h0040};
    wdata = '0;

    // Reset held with both requesting.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);

    // Round-robin contention, first cycle after release.
    next_cycle();
    rst = 1'b1;
    #1;
    chk("rr0_gnt", 32'(gnt), 32'h1);
    chk("rr0_addr", 32'(mem_addr), 32'h40);
    next_cycle(); #1;
    chk("rr1_gnt", 32'(gnt), 32'h2);
    chk("rr1_addr", 32'(mem_addr), 32'h41);
    chk("rr1_rvalid", 32'(rvalid), 32'h1);
    chk("rr1_rdata", 32'(rdata), 32'h2000);
    next_cycle(); #1;
    chk("rr2_gnt", 32'(gnt), 32'h1);
    chk("rr2_rvalid", 32'(rvalid), 32'h2);
    chk("rr2_rdata", 32'(rdata), 32'h3000);
    next_cycle(); #1;
    chk("rr3_gnt", 32'(gnt), 32'h2);
    chk("rr3_rvalid", 32'(rvalid), 32'h1);
    chk("rr3_rdata", 32'(rdata), 32'h2000);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00);
    #1;
    chk("rr4_gnt", 32'(gnt), 32'h0);
    chk("rr4_rvalid", 32'(rvalid), 32'h2);
    chk("rr4_rdata", 32'(rdata), 32'h3000);

    // Write by req0, then read back by req1.
    next_cycle();
    drive(2'b01, 2'b00, 2'b01);
    addr  = {16'h0041, 16'h0042};
    wdata = {16'h0000, 16'h4000};
    #1;
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_we", 32'(mem_we), 32'h1);
    chk("wr_addr", 32'(mem_addr), 32'h42);
    chk("wr_wdata", 32'(mem_wdata), 32'h4000);
    chk("wr_rvalid_prev", 32'(rvalid), 32'h0);
    next_cycle();
    drive(2'b10, 2'b00, 2'b00);
    addr = {16'h0042, 16'h0040};
    #1;
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_we", 32'(mem_we), 32'h0);
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00);
    #1;
    chk("rd_rvalid", 32'(rvalid), 32'h2);
    chk("rd_rdata", 32'(rdata), 32'h4000);

    // Burst lock by req0 with req1 contending: 4 grants, then req1, then req0.
    next_cycle();
    drive(2'b11, 2'b01, 2'b00);
    addr = {16'h0041, 16'h0040};
    #1;
    chk("bl0_gnt", 32'(gnt), 32'h1);
    next_cycle(); #1;
    chk("bl1_gnt", 32'(gnt), 32'h1);
    chk("bl1_rvalid", 32'(rvalid), 32'h1);
    chk("bl1_rdata", 32'(rdata), 32'h2000);
    next_cycle(); #1;
    chk("bl2_gnt", 32'(gnt), 32'h1);
    next_cycle(); #1;
    chk("bl3_gnt", 32'(gnt), 32'h1);
    next_cycle(); #1;
    chk("bl4_gnt", 32'(gnt), 32'h2);
    next_cycle(); #1;
    chk("bl5_gnt", 32'(gnt), 32'h1);
    // req0 abandons while locked: no grant this cycle, req1 next.
    next_cycle();
    drive(2'b10, 2'b00, 2'b00);
    #1;
    chk("abandon_gnt", 32'(gnt), 32'h0);
    next_cycle(); #1;
    chk("abandon_next", 32'(gnt), 32'h2);

    // Early lock release: lock for 2 grants, drop on the 3rd.
    next_cycle();
    drive(2'b00, 2'b00, 2'b00);
    next_cycle();
    drive(2'b11, 2'b01, 2'b00);
    #1;
    chk("er0_gnt", 32'(gnt), 32'h1);
    next_cycle(); #1;
    chk("er1_gnt", 32'(gnt), 32'h1);
    next_cycle();
    lock = 2'b00;
    #1;
    chk("er2_gnt", 32'(gnt), 32'h1);
    next_cycle(); #1;
    chk("er3_gnt", 32'(gnt), 32'h2);

    // Reset mid-burst with a read in flight.
    next_cycle();
    drive(2'b01, 2'b01, 2'b00);
    #1;
    chk("mr_gnt", 32'(gnt), 32'h1);
    next_cycle();
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00);
    #1;
    chk("mr_rvalid_drop", 32'(rvalid), 32'h0);
    chk("mr_gnt_rst", 32'(gnt), 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(2'b10, 2'b00, 2'b00);
    #1;
    chk("mr_idle_gnt", 32'(gnt), 32'h2);
    chk("mr_rvalid_after", 32'(rvalid), 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00);
    #1;
    chk("mr_read_rvalid", 32'(rvalid), 32'h2);
    chk("mr_read_rdata", 32'(rdata), 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one synchronous BRAM port between NUM_REQ requesters, e.g. a program loader, a display reader and a debug reader on the port not owned by the datapath.
- Round-robin arbitration with an optional bounded burst lock.
- Single-cycle grant; read data is returned one cycle after the granted read, tagged by requester.
- Sits between the requesters and the bram port's addr/we/data/q pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory data width.
- MAX_BURST, 8, maximum consecutive grants to one locked owner (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester; held high until granted.
- lock  in  NUM_REQ  owner wants to keep the port after this access.
- we  in  NUM_REQ  1 = write, 0 = read, per requester.
- addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses slice i.
- wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  one-hot/zero; access occurs in the cycle gnt[i]=1.
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  DATA_WIDTH  read data, shared by all requesters, qualified by rvalid.
- mem_addr  out  ADDR_WIDTH  to bram addr.
- mem_we  out  1  to bram we.
- mem_wdata  out  DATA_WIDTH  to bram data.
- mem_rdata  in  DATA_WIDTH  from bram q; valid one cycle after addr is sampled.

Behaviour:
- Reset (rst=0, asynchronous):
  - owner_valid=0, last_gnt=NUM_REQ-1, so requester 0 wins the first tie.
  - burst_cnt=0, rvalid=0.
  - Combinational outputs resolve to gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
- State machine, 2 states:
  - IDLE: no owner. gnt = the first asserted req searching upward from last_gnt+1 (mod NUM_REQ). If granted with lock=1, go to LOCKED, owner=i, burst_cnt=1. Otherwise stay in IDLE.
  - LOCKED: gnt[owner]=req[owner]; all other requesters are blocked.
    - On each granted cycle, burst_cnt++.
    - Exit to IDLE when the granted lock[owner]=0, or burst_cnt reaches MAX_BURST, or req[owner]=0 for one cycle (owner abandons).
    - The exit cycle's access still completes. The next arbitration excludes the old owner if any other req is set.
- gnt is combinational from req and state; no more than one bit is set. Requesters must hold addr/we/wdata stable while req=1 and gnt=0.
- Mux: mem_addr/mem_wdata take the granted slice; mem_we = |(gnt & we). With no grant, mem_addr=0 and mem_we=0.
- last_gnt updates to the granted index on every granted cycle.
- Read latency: gnt[i]&!we[i] at cycle N gives rvalid[i]=1 at cycle N+1, with rdata = mem_rdata (passthrough) in that cycle.
- Back-to-back reads (one per cycle, any requester mix) give one rvalid per cycle, in order.
- Write grants never produce rvalid.
- MAX_BURST=1: lock is effectively ignored and arbitration is pure round-robin.
- Reset mid-burst returns to IDLE. A pending rvalid is dropped and must not appear after reset release.
- lock from a non-granted requester is ignored.

Decomposition:
- Shared package:
  - Arbiter state encoding (ARB_IDLE, ARB_LOCKED).
  - Default ADDR/DATA width constants, shared with datapath and bram.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are req vector and last index; outputs are the one-hot grant and its index.
- FSM, burst counter, mux and rvalid pipeline stay in bram_port_arbiter.

Test Plan:
- Reset: hold rst=0 with req=2'b11 → gnt=0, mem_we=0, rvalid=0. First cycle after release → gnt=2'b01.
- Round-robin contention: req=2'b11 for 4 cycles, reads of 0x0040 (req0) and 0x0041 (req1), bram preloaded 0x2000/0x3000 → gnt sequence 01,10,01,10. rvalid follows one cycle later with rdata 0x2000,0x3000,0x2000,0x3000.
- Write then read: req0 writes 0x4000 to 0x0042 → mem_we=1 that cycle, no rvalid. req1 then reads 0x0042 → rvalid[1]=1 with rdata=0x4000 the next cycle.
- Burst lock: MAX_BURST=4, req0 lock=1 with 6 reads, req1 requesting throughout → gnt=01 ×4, then 10, then 01.
- Lock release early: req0 lock=1 for 2 grants, then lock=0 on the 3rd → 3 grants to req0, then req1 is granted on the next cycle.
- Reset mid-operation: assert rst=0 in the cycle after a granted read → no rvalid seen, arbiter back in IDLE with last_gnt reset.
